// File: rtl/noc_link_buffer.sv
// Credit-based NoC link buffer: local flit FIFO advertised upstream as credits,
// forwarding registered flits downstream only while downstream credits remain.
module noc_link_buffer #(
  parameter int FLIT_WIDTH         = 128,
  parameter int DEST_WIDTH         = 6,
  parameter int BUFFER_DEPTH       = 4,
  parameter int DOWNSTREAM_CREDITS = 1
) (
  input  logic                                  clk_noc,
  input  logic                                  rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]                 data_in,
  input  logic [DEST_WIDTH-1:0]                 dest_in,
  input  logic                                  is_tail_in,
  input  logic                                  send_in,
  output logic                                  credit_out,
  output logic [FLIT_WIDTH-1:0]                 data_out,
  output logic [DEST_WIDTH-1:0]                 dest_out,
  output logic                                  is_tail_out,
  output logic                                  send_out,
  input  logic                                  credit_in,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     occupancy,
  output logic                                  overflow_err,
  output logic                                  credit_err
);

  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int PTR_W   = $clog2(BUFFER_DEPTH);
  localparam int OCC_W   = $clog2(BUFFER_DEPTH + 1);
  localparam int CRD_W   = $clog2(DOWNSTREAM_CREDITS + 1);

  logic [ENTRY_W-1:0] mem [BUFFER_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0] count_reg, count_next;
  logic [CRD_W-1:0] credit_reg, credit_next;
  logic             overflow_reg, overflow_next;
  logic             credit_err_reg, credit_err_next;
  logic             send_reg, credit_out_reg;
  logic [ENTRY_W-1:0] out_reg;

  logic pop, push, full, credit_full;

  always_comb begin
    full        = (count_reg == OCC_W'(BUFFER_DEPTH));
    credit_full = (credit_reg == CRD_W'(DOWNSTREAM_CREDITS));
    pop         = (count_reg != '0) && (credit_reg != '0);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push        = send_in && (!full || pop);

    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    credit_next = credit_reg;
    overflow_next   = overflow_reg || (send_in && full && !pop);
    credit_err_next = credit_err_reg || (credit_in && !pop && credit_full);

    if (push)
      wr_ptr_next = (wr_ptr_reg == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
    if (pop)
      rd_ptr_next = (rd_ptr_reg == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_next = count_reg + OCC_W'(1);
      2'b01:   count_next = count_reg - OCC_W'(1);
      default: count_next = count_reg;
    endcase

    if (pop && !credit_in)
      credit_next = credit_reg - CRD_W'(1);
    else if (credit_in && !pop && !credit_full)
      credit_next = credit_reg + CRD_W'(1);
  end

  // Storage has no reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk_noc) begin
    if (!rst_noc_sync && push)
      mem[wr_ptr_reg] <= {data_in, dest_in, is_tail_in};
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      credit_reg     <= CRD_W'(DOWNSTREAM_CREDITS);
      overflow_reg   <= 1'b0;
      credit_err_reg <= 1'b0;
      send_reg       <= 1'b0;
      credit_out_reg <= 1'b0;
      out_reg        <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      credit_reg     <= credit_next;
      overflow_reg   <= overflow_next;
      credit_err_reg <= credit_err_next;
      send_reg       <= pop;
      credit_out_reg <= pop;
      if (pop)
        out_reg <= mem[rd_ptr_reg];
    end
  end

  assign {data_out, dest_out, is_tail_out} = out_reg;
  assign send_out     = send_reg;
  assign credit_out   = credit_out_reg;
  assign occupancy    = count_reg;
  assign overflow_err = overflow_reg;
  assign credit_err   = credit_err_reg;

endmodule

// File: tb/tb_noc_link_buffer.sv
// Bench for noc_link_buffer: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model of the link buffer.
module tb_noc_link_buffer;

  localparam int FW    = 16;
  localparam int DW    = 6;
  localparam int DEPTH = 5;
  localparam int CRED  = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [FW-1:0] data;
    logic [DW-1:0] dest;
    logic          tail;
  } flit_t;

  logic             clk_noc = 1'b0;
  logic             rst_noc_sync = 1'b1;
  logic [FW-1:0]    data_in = '0;
  logic [DW-1:0]    dest_in = '0;
  logic             is_tail_in = 1'b0;
  logic             send_in = 1'b0;
  logic             credit_out;
  logic [FW-1:0]    data_out;
  logic [DW-1:0]    dest_out;
  logic             is_tail_out;
  logic             send_out;
  logic             credit_in = 1'b0;
  logic [OCC_W-1:0] occupancy;
  logic             overflow_err;
  logic             credit_err;

  always #5 clk_noc = ~clk_noc;

  noc_link_buffer #(
    .FLIT_WIDTH(FW),
    .DEST_WIDTH(DW),
    .BUFFER_DEPTH(DEPTH),
    .DOWNSTREAM_CREDITS(CRED)
  ) dut (
    .clk_noc(clk_noc),
    .rst_noc_sync(rst_noc_sync),
    .data_in(data_in),
    .dest_in(dest_in),
    .is_tail_in(is_tail_in),
    .send_in(send_in),
    .credit_out(credit_out),
    .data_out(data_out),
    .dest_out(dest_out),
    .is_tail_out(is_tail_out),
    .send_out(send_out),
    .credit_in(credit_in),
    .occupancy(occupancy),
    .overflow_err(overflow_err),
    .credit_err(credit_err)
  );

  // Reference model state
  flit_t mq[$];
  int    m_credits = CRED;
  bit    m_send, m_credit_out, m_ovf, m_cerr;
  flit_t m_out = '0;

  int n_checks = 0;
  int n_fails  = 0;
  int n_sent   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int    sz;
    bit    pop;
    flit_t f;
    if (rst_noc_sync) begin
      mq.delete();
      m_credits    = CRED;
      m_send       = 1'b0;
      m_credit_out = 1'b0;
      m_out        = '0;
      m_ovf        = 1'b0;
      m_cerr       = 1'b0;
    end else begin
      sz  = mq.size();
      pop = (sz > 0) && (m_credits > 0);
      m_send       = pop;
      m_credit_out = pop;
      if (pop) m_out = mq.pop_front();
      if (send_in) begin
        f = '{data: data_in, dest: dest_in, tail: is_tail_in};
        if (sz < DEPTH || pop) mq.push_back(f);
        else m_ovf = 1'b1;
      end
      if (credit_in && !pop && m_credits == CRED) m_cerr = 1'b1;
      else m_credits = m_credits + int'(credit_in) - int'(pop);
    end
  endtask

  task automatic check_outputs();
    check_val("send_out", send_out, m_send);
    check_val("credit_out", credit_out, m_credit_out);
    check_val("data_out", data_out, m_out.data);
    check_val("dest_out", dest_out, m_out.dest);
    check_val("is_tail_out", is_tail_out, m_out.tail);
    check_val("occupancy", occupancy, mq.size());
    check_val("overflow_err", overflow_err, m_ovf);
    check_val("credit_err", credit_err, m_cerr);
    if (m_send) begin
      n_sent++;
      $display("xfer %0d t=%0t data=%h dest=%h tail=%b", n_sent, $time, data_out, dest_out, is_tail_out);
    end
  endtask

  task automatic step(input bit s, input flit_t f, input bit c, input bit r);
    send_in      = s;
    data_in      = f.data;
    dest_in      = f.dest;
    is_tail_in   = f.tail;
    credit_in    = c;
    rst_noc_sync = r;
    @(posedge clk_noc);
    model_edge();
    #1;
    check_outputs();
  endtask

  function automatic flit_t rand_flit();
    flit_t f;
    f.data = FW'($urandom);
    f.dest = DW'($urandom);
    f.tail = 1'($urandom);
    return f;
  endfunction

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, 1'b1);
  endtask

  // Wait (bounded) until the model FIFO is empty; a stuck FIFO shows as a failure.
  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20 && mq.size() > 0; i++) idle();
    check_val(tag, occupancy, 0);
  endtask

  // After reset, send CRED flits so the downstream credit counter reaches zero.
  task automatic drain_credits();
    for (int i = 0; i < CRED; i++) step(1'b1, rand_flit(), 1'b0, 1'b0);
    wait_empty("drain_empty");
  endtask

  initial begin
    flit_t f;

    // Reset state
    do_reset();
    do_reset();
    check_val("rst_send", send_out, 0);
    check_val("rst_occ", occupancy, 0);

    // Single flit: data 0xA5, dest 9, tail at edge 0 -> out after edge 1
    f = '{data: FW'(16'h00A5), dest: DW'(6'h09), tail: 1'b1};
    step(1'b1, f, 1'b0, 1'b0);
    check_val("single_early", send_out, 0);
    idle();
    check_val("single_send", send_out, 1);
    check_val("single_credit", credit_out, 1);
    check_val("single_data", data_out, 16'h00A5);
    check_val("single_dest", dest_out, 6'h09);
    idle();
    check_val("single_hold", data_out, 16'h00A5);
    idle();
    step(1'b0, '0, 1'b1, 1'b0);

    // Credit stall: 4 back-to-back flits, only CRED go out
    for (int i = 0; i < 4; i++) step(1'b1, rand_flit(), 1'b0, 1'b0);
    idle();
    idle();
    check_val("stall_occ", occupancy, 4 - CRED);
    for (int i = 0; i < 4 - CRED; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      idle();
      idle();
    end
    wait_empty("stall_empty");

    // Credit error: restore credits to full, then one extra pulse
    for (int i = 0; i < 2 * CRED && m_credits < CRED; i++) step(1'b0, '0, 1'b1, 1'b0);
    check_val("cerr_before", credit_err, 0);
    step(1'b0, '0, 1'b1, 1'b0);
    check_val("cerr_set", credit_err, 1);
    idle();
    check_val("cerr_sticky", credit_err, 1);

    // Overflow with no credits
    do_reset();
    drain_credits();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, rand_flit(), 1'b0, 1'b0);
    check_val("ovf_occ", occupancy, DEPTH);
    check_val("ovf_err", overflow_err, 1);
    idle();
    check_val("ovf_send", send_out, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    drain_credits();
    for (int i = 0; i < DEPTH; i++) step(1'b1, rand_flit(), 1'b0, 1'b0);
    check_val("full_occ", occupancy, DEPTH);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, rand_flit(), 1'b0, 1'b0);
    check_val("pp_occ", occupancy, DEPTH);
    check_val("pp_ovf", overflow_err, 0);
    check_val("pp_send", send_out, 1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      idle();
    end
    wait_empty("pp_empty");

    // Reset mid-packet: three buffered flits are discarded
    do_reset();
    drain_credits();
    for (int i = 0; i < 3; i++) step(1'b1, rand_flit(), 1'b0, 1'b0);
    check_val("mid_occ", occupancy, 3);
    step(1'b1, rand_flit(), 1'b1, 1'b1);
    check_val("mid_rst_occ", occupancy, 0);
    check_val("mid_rst_data", data_out, 0);
    check_val("mid_rst_send", send_out, 0);
    for (int i = 0; i < 4; i++) idle();
    check_val("mid_no_emit", send_out, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 60, rand_flit(), $urandom_range(0, 99) < 45,
           $urandom_range(0, 199) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/noc_link_buffer.md
NOC_LINK_BUFFER -- requirements
Module: noc_link_buffer

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 128: flit payload width.
REQ-002 SHALL have parameter DEST_WIDTH, default 6: flit destination width (TDEST+TID).
REQ-003 SHALL have parameter BUFFER_DEPTH, default 4, legal 2..64: local flit FIFO entries, equal to the credits advertised upstream.
REQ-004 SHALL have parameter DOWNSTREAM_CREDITS, default 1, legal >=1: credits granted by the downstream router input buffer (its FLIT_BUFFER_DEPTH).
REQ-005 SHALL have ports:
- clk_noc  in  1  NoC clock; all logic on its rising edge
- rst_noc_sync  in  1  synchronous active-high reset
- data_in  in  FLIT_WIDTH  upstream flit payload
- dest_in  in  DEST_WIDTH  upstream flit destination
- is_tail_in  in  1  upstream tail marker
- send_in  in  1  upstream flit valid, one flit per cycle high
- credit_out  out  1  one-cycle pulse returning one credit upstream
- data_out  out  FLIT_WIDTH  downstream flit payload
- dest_out  out  DEST_WIDTH  downstream flit destination
- is_tail_out  out  1  downstream tail marker
- send_out  out  1  downstream flit valid
- credit_in  in  1  one-cycle pulse, one credit returned from downstream
- occupancy  out  clog2(BUFFER_DEPTH+1)  FIFO entry count
- overflow_err  out  1  sticky: flit arrived with FIFO full
- credit_err  out  1  sticky: credit_in with counter already at DOWNSTREAM_CREDITS

Function
REQ-006 SHALL write {data_in, dest_in, is_tail_in} into the FIFO on every edge with send_in=1, no backpressure toward upstream.
REQ-007 SHALL, on send_in=1 with FIFO full and no pop on the same edge, drop the flit, leave FIFO unchanged, and set overflow_err.
REQ-008 SHALL treat simultaneous push and pop on a full FIFO as legal: write accepted, occupancy unchanged, no error.
REQ-009 SHALL keep a downstream credit counter, width clog2(DOWNSTREAM_CREDITS+1), initialised to DOWNSTREAM_CREDITS.
REQ-010 SHALL pop the FIFO head on an edge iff FIFO non-empty (occupancy before the edge) and credit counter > 0.
REQ-011 SHALL decrement the counter on pop, increment on credit_in, and leave it unchanged when both occur on the same edge.
REQ-012 SHALL, on credit_in with counter = DOWNSTREAM_CREDITS and no pop, hold the counter saturated and set credit_err.
REQ-013 SHALL register outputs: a pop at edge k drives send_out=1 and the head flit onto data_out/dest_out/is_tail_out for the cycle after edge k; send_out=0 otherwise.
REQ-014 SHALL hold data_out/dest_out/is_tail_out at the last sent flit while send_out=0.
REQ-015 SHALL assert credit_out for exactly one cycle in the same cycle send_out is asserted for the popped flit.
REQ-016 SHALL have latency 2 edges (no fall-through): flit sampled at edge k gives send_out=1 at the earliest after edge k+1.
REQ-017 SHALL sustain one flit per cycle when DOWNSTREAM_CREDITS covers the downstream credit round trip.
REQ-018 SHALL preserve flit order and forward is_tail unchanged; no packet-level interpretation.
REQ-019 SHALL update occupancy registered: +1 push, -1 pop, unchanged for both or neither.
REQ-020 SHALL wrap FIFO read and write pointers modulo BUFFER_DEPTH, including non-power-of-two depths.

Reset
REQ-021 SHALL, while rst_noc_sync=1 at an edge, clear FIFO, occupancy=0, credit counter=DOWNSTREAM_CREDITS, send_out=0, credit_out=0, data_out/dest_out/is_tail_out=0, overflow_err=0, credit_err=0.
REQ-022 SHALL discard in-flight flits and ignore send_in/credit_in on edges where rst_noc_sync=1, including reset asserted mid-packet.
REQ-023 SHALL have no reset-dependent behaviour other than REQ-021/022; errors clear only by reset.

Verification
REQ-024 Single flit: DOWNSTREAM_CREDITS=1, send_in one cycle with data 0xA5, dest 6'h09, tail=1 at edge 0 -> send_out and credit_out high in cycle after edge 1, data_out=0xA5, counter 0; credit_in at edge 4 -> counter 1.
REQ-025 Credit stall: DOWNSTREAM_CREDITS=1, 4 back-to-back flits, no credit_in -> one flit sent, occupancy 3; three credit_in pulses spaced 3 cycles -> remaining flits sent in order, one per credit, occupancy 0.
REQ-026 Overflow: BUFFER_DEPTH=4, no credits (counter drained), 5 flits back-to-back -> occupancy 4, overflow_err=1 after 5th edge, 5th flit never emitted.
REQ-027 Full push+pop: FIFO full, credit available, send_in same edge as pop -> occupancy stays 4, overflow_err=0, order preserved.
REQ-028 Credit error: counter at DOWNSTREAM_CREDITS=2, credit_in pulse with FIFO empty -> credit_err=1, counter stays 2.
REQ-029 Reset mid-packet: 3 flits buffered, rst_noc_sync 1 cycle -> all outputs 0, occupancy 0, counter=DOWNSTREAM_CREDITS, buffered flits never emitted.
